execute_stage_controller: RTL and testbench
===========================================

Name: execute_stage_controller

Overview:
Sequences the execute stage of the pipeline. It accepts one decoded instruction at a time from decode through a valid/ready handshake and holds its operands and control struct stable. It drives the executor's enable for 1 cycle (ALU/branch ops) or a fixed multi-cycle window (mul/div), then captures the result, jump flag and target. It presents the captured result to the memory stage and issues a one-cycle redirect pulse to fetch for taken jumps; it also handles pipeline flush.

Parameters:
XLEN, 64, datapath width
MUL_LAT, 3, execute cycles for multiply ops (>=1)
DIV_LAT, 8, execute cycles for divide/remainder ops (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  decode has an instruction
in_ready  out  1  controller can accept
in_pc  in  XLEN  instruction PC
in_rs1  in  XLEN  operand A
in_rs2  in  XLEN  operand B
in_ctrl  in  control_signals_struct  decoded control
in_kind  in  2  00 single-cycle, 01 mul, 10 div, 11 reserved (treated as 00)
ex_enable  out  1  enable to executor
ex_pc  out  XLEN  latched PC to executor
ex_rs1  out  XLEN  latched operand A
ex_rs2  out  XLEN  latched operand B
ex_ctrl  out  control_signals_struct  latched control to executor
ex_done  in  1  executor completion
ex_result  in  XLEN  executor ALU result
ex_jump  in  1  executor jump_signal
ex_target  in  XLEN  executor jump target
out_valid  out  1  result available to memory stage
out_ready  in  1  memory stage accepts
out_result  out  XLEN  captured result
out_pc  out  XLEN  captured PC
out_ctrl  out  control_signals_struct  captured control, jump_signal = captured jump
redirect_valid  out  1  one-cycle taken-jump pulse to fetch
redirect_pc  out  XLEN  jump target
flush  in  1  kill in-flight instruction
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, HOLD. Reset (any state, including mid-EXEC) -> IDLE; all outputs 0; latched registers and cycle counter cleared.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). Accept happens when in_valid && in_ready: latch pc/rs1/rs2/ctrl. Load counter with 0 for single-cycle, MUL_LAT-1 for mul, DIV_LAT-1 for div. Next state EXEC.
- EXEC: ex_enable=1 for every EXEC cycle; ex_* outputs hold latched values. Counter decrements while nonzero. Completion cycle = counter==0 && ex_done. At completion, capture ex_result, ex_jump, ex_target; next state HOLD. If counter==0 && !ex_done, remain in EXEC with enable held (no timeout).
- Latency: single-cycle op accepted at cycle T -> ex_enable at T+1 -> out_valid at T+2. Mul: out_valid at T+1+MUL_LAT. Div: out_valid at T+1+DIV_LAT.
- HOLD: out_valid=1 and out_* stable until out_ready. On out_ready: accept a new instruction in the same cycle if in_valid (-> EXEC), else -> IDLE. No bubble is inserted for back-to-back ops.
- redirect_valid=1 exactly in the first HOLD cycle when the captured jump=1; redirect_pc = captured target; otherwise redirect_pc=0. The pulse is not repeated while HOLD stalls.
- flush (highest priority after reset): in any state -> IDLE next cycle. Drop the in-flight op. No out_valid, no redirect. in_ready=0 during the flush cycle, so no accept occurs. A flush coincident with a completion cycle discards the result.
- ex_enable=0 outside EXEC. out_valid=0 outside HOLD.
- Target arithmetic is done by the executor; the controller never modifies widths or values, it only registers them.

Test Plan:
- ADD (kind 00), in_pc=0x1000, ex_result=0x2A returned with ex_done -> ex_enable high 1 cycle; out_valid 2 cycles after accept with out_result=0x2A, out_pc=0x1000; redirect_valid stays 0.
- MUL (kind 01), MUL_LAT=3 -> ex_enable high exactly 3 cycles; out_valid at accept+4; DIV with DIV_LAT=8 -> out_valid at accept+9.
- JAL, ex_jump=1, ex_target=0x1040 -> redirect_valid high exactly 1 cycle with redirect_pc=0x1040. Hold out_ready=0 for 5 cycles -> no second pulse; out_ctrl.jump_signal=1 throughout.
- Back-to-back: 4 single-cycle ops with out_ready=1 and in_valid continuously high -> one result every 2 cycles, in order. in_ready toggles as specified and no op is lost or duplicated.
- flush asserted in the 2nd cycle of a DIV -> IDLE next cycle; no out_valid, no redirect. The next op is accepted normally.
- reset asserted mid-MUL while ex_done=1 -> all outputs 0 next cycle; state IDLE; busy=0.

Source files
------------

// File: rtl/execute_stage_controller.sv
// Execute-stage sequencer: takes one decoded op from decode, runs the executor for 1 or
// MUL_LAT/DIV_LAT cycles, then holds the captured result for the memory stage.
package execute_stage_pkg;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump_signal;
  } control_signals_struct;
endpackage

// state | meaning
// IDLE  | empty, ready to accept from decode
// EXEC  | executor enabled; window counter runs down to 0, then waits for ex_done
// HOLD  | captured result presented to memory stage until out_ready
module execute_stage_controller
  import execute_stage_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_rs1,
  input  logic [XLEN-1:0]       in_rs2,
  input  control_signals_struct in_ctrl,
  input  logic [1:0]            in_kind,
  output logic                  ex_enable,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1,
  output logic [XLEN-1:0]       ex_rs2,
  output control_signals_struct ex_ctrl,
  input  logic                  ex_done,
  input  logic [XLEN-1:0]       ex_result,
  input  logic                  ex_jump,
  input  logic [XLEN-1:0]       ex_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [XLEN-1:0]       out_pc,
  output control_signals_struct out_ctrl,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  input  logic                  flush,
  output logic                  busy
);

  localparam int CNT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_load;
  logic [XLEN-1:0]       pc_q, rs1_q, rs2_q, result_q, target_q;
  control_signals_struct ctrl_q;
  logic                  jump_q, first_hold_q;
  logic                  accept, complete;

  always_comb begin
    in_ready  = !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
    accept    = in_valid && in_ready;
    complete  = (state == EXEC) && (cnt_q == '0) && ex_done;
    state_nxt = state;
    case (in_kind)
      2'b01:   cnt_load = CNT_W'(MUL_LAT - 1);
      2'b10:   cnt_load = CNT_W'(DIV_LAT - 1);
      default: cnt_load = '0;
    endcase
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (complete) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt_q        <= '0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      target_q     <= '0;
      jump_q       <= 1'b0;
      first_hold_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pc_q   <= in_pc;
        rs1_q  <= in_rs1;
        rs2_q  <= in_rs2;
        ctrl_q <= in_ctrl;
        cnt_q  <= cnt_load;
      end else if ((state == EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // A flush landing on the completion cycle discards the result entirely.
      if (complete && !flush) begin
        result_q <= ex_result;
        jump_q   <= ex_jump;
        target_q <= ex_target;
      end
      first_hold_q <= complete && !flush;
    end
  end

  always_comb begin
    ex_enable            = (state == EXEC);
    ex_pc                = pc_q;
    ex_rs1               = rs1_q;
    ex_rs2               = rs2_q;
    ex_ctrl              = ctrl_q;
    out_valid            = (state == HOLD) && !flush;
    out_result           = result_q;
    out_pc               = pc_q;
    out_ctrl             = ctrl_q;
    out_ctrl.jump_signal = jump_q;
    // Redirect fires once on HOLD entry, never again while memory stalls.
    redirect_valid       = (state == HOLD) && first_hold_q && jump_q && !flush;
    redirect_pc          = redirect_valid ? target_q : '0;
    busy                 = (state != IDLE);
  end

endmodule

// File: tb/tb_execute_stage_controller.sv
// Directed bench for execute_stage_controller: vector table of single ops plus
// hand sequences for back-to-back, flush and mid-op reset.
module tb_execute_stage_controller;
  import execute_stage_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rs1, in_rs2;
  control_signals_struct in_ctrl;
  logic [1:0] in_kind;
  logic ex_enable;
  logic [XLEN-1:0] ex_pc, ex_rs1, ex_rs2;
  control_signals_struct ex_ctrl;
  logic ex_done, ex_jump;
  logic [XLEN-1:0] ex_result, ex_target;
  logic out_valid, out_ready;
  logic [XLEN-1:0] out_result, out_pc;
  control_signals_struct out_ctrl;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic flush, busy;

  always #5 clk = ~clk;

  execute_stage_controller #(.XLEN(XLEN), .MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_ctrl(in_ctrl), .in_kind(in_kind),
    .ex_enable(ex_enable), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_ctrl(ex_ctrl), .ex_done(ex_done), .ex_result(ex_result), .ex_jump(ex_jump),
    .ex_target(ex_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_pc(out_pc), .out_ctrl(out_ctrl),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .busy(busy)
  );

  typedef struct {
    logic [XLEN-1:0]       pc, rs1, rs2, result, target;
    control_signals_struct ctrl;
    logic [1:0]            kind;
    logic                  jump;
    int                    lat, stall, hold;
  } vec_t;

  vec_t vecs[7];
  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [63:0] pc, input logic [63:0] rs1,
                              input logic [63:0] rs2, input control_signals_struct ctrl,
                              input logic [1:0] kind, input logic [63:0] result,
                              input logic jump, input logic [63:0] target,
                              input int stall, input int hold);
    vec_t v;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.ctrl = ctrl; v.kind = kind;
    v.result = result; v.jump = jump; v.target = target;
    v.stall = stall; v.hold = hold;
    v.lat = (kind == 2'b01) ? 3 : (kind == 2'b10) ? 8 : 1;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int cyc, en;
    logic got, en_bad, hold_bad;
    control_signals_struct exp_ctrl;
    @(negedge clk);
    chk($sformatf("%s_in_ready", tag), {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_pc = v.pc; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_ctrl = v.ctrl; in_kind = v.kind;
    ex_result = v.result; ex_jump = v.jump; ex_target = v.target;
    ex_done = (v.stall == 0);
    @(posedge clk);
    cyc = 0; en = 0; got = 1'b0; en_bad = 1'b0; hold_bad = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      in_valid = 1'b0; in_pc = '1; in_rs1 = '1; in_rs2 = '1; in_ctrl = '1; in_kind = 2'b00;
      cyc++;
      if (ex_enable) begin
        en++;
        if (ex_pc !== v.pc || ex_rs1 !== v.rs1 || ex_rs2 !== v.rs2 || ex_ctrl !== v.ctrl)
          en_bad = 1'b1;
        if (v.stall != 0 && en >= v.lat + v.stall) ex_done = 1'b1;
      end
      if (out_valid) got = 1'b1;
    end
    exp_ctrl = v.ctrl;
    exp_ctrl.jump_signal = v.jump;
    chk($sformatf("%s_out_valid_seen", tag), {63'd0, got}, 64'd1);
    chk($sformatf("%s_latency", tag), 64'(cyc), 64'(v.lat + 1 + v.stall));
    chk($sformatf("%s_enable_cycles", tag), 64'(en), 64'(v.lat + v.stall));
    chk($sformatf("%s_ex_operands", tag), {63'd0, en_bad}, 64'd0);
    chk($sformatf("%s_out_result", tag), out_result, v.result);
    chk($sformatf("%s_out_pc", tag), out_pc, v.pc);
    chk($sformatf("%s_out_ctrl", tag), 64'(out_ctrl), 64'(exp_ctrl));
    chk($sformatf("%s_redirect_valid", tag), {63'd0, redirect_valid}, {63'd0, v.jump});
    chk($sformatf("%s_redirect_pc", tag), redirect_pc, v.jump ? v.target : 64'd0);
    out_ready = (v.hold == 0);
    for (int h = 1; h <= v.hold; h++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || redirect_valid !== 1'b0 ||
          out_ctrl.jump_signal !== v.jump || out_result !== v.result)
        hold_bad = 1'b1;
      out_ready = (h == v.hold);
    end
    chk($sformatf("%s_hold_stable", tag), {63'd0, hold_bad}, 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s_after_out_valid", tag), {63'd0, out_valid}, 64'd0);
    chk($sformatf("%s_after_busy", tag), {63'd0, busy}, 64'd0);
    chk($sformatf("%s_after_redirect", tag), {63'd0, redirect_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, last, seen;
    logic spacing_bad, tog_bad;
    control_signals_struct c_alu, c_jal, c_br;
    c_alu = '{alu_op: 4'h0, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b1, branch: 1'b0, jump_signal: 1'b0};
    c_jal = '{alu_op: 4'h5, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b1, branch: 1'b0, jump_signal: 1'b0};
    c_br  = '{alu_op: 4'h9, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0, branch: 1'b1, jump_signal: 1'b1};

    vecs[0] = mk(64'h1000, 64'h20, 64'h0A, c_alu, 2'b00, 64'h2A, 1'b0, 64'h0, 0, 0);
    vecs[1] = mk(64'h1004, 64'h7, 64'h6, c_alu, 2'b01, 64'd42, 1'b0, 64'h0, 0, 0);
    vecs[2] = mk(64'h1008, 64'h80, 64'h8, c_alu, 2'b10, 64'h10, 1'b0, 64'h0, 0, 0);
    vecs[3] = mk(64'h100C, 64'h0, 64'h0, c_jal, 2'b00, 64'h1010, 1'b1, 64'h1040, 0, 5);
    vecs[4] = mk(64'h1010, 64'h1, 64'h2, c_br, 2'b11, 64'hDEAD, 1'b0, 64'h2000, 0, 0);
    vecs[5] = mk(64'h1014, 64'h3, 64'h4, c_alu, 2'b00, 64'hBEEF_0000_1234, 1'b0, 64'h0, 2, 0);
    vecs[6] = mk(64'h1018, 64'h5, 64'h5, c_br, 2'b01, 64'h1, 1'b1, 64'h0F00, 0, 2);

    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_ctrl = '0;
    in_kind = 2'b00; ex_done = 1'b0; ex_result = '0; ex_jump = 1'b0; ex_target = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ex_enable", {63'd0, ex_enable}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("v%0d", i));

    // Back-to-back single-cycle ops with memory always ready.
    out_ready = 1'b1; ex_done = 1'b1; ex_jump = 1'b0; in_kind = 2'b00; in_ctrl = c_alu;
    sent = 0; rcv = 0; last = -1; spacing_bad = 1'b0; tog_bad = 1'b0;
    for (int c = 0; c < 30 && rcv < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk($sformatf("b2b_pc%0d", rcv), out_pc, 64'h2000 + 64'(16 * rcv));
        chk($sformatf("b2b_res%0d", rcv), out_result, 64'h2005 + 64'(16 * rcv));
        if (rcv > 0 && c - last != 2) spacing_bad = 1'b1;
        last = c;
        rcv++;
      end
      if (sent > 0 && in_ready !== out_valid) tog_bad = 1'b1;
      in_valid = (sent < 4);
      in_pc = 64'h2000 + 64'(16 * sent);
      in_rs1 = 64'(sent);
      ex_result = ex_pc + 64'd5;
      if (in_valid && in_ready) sent++;
    end
    chk("b2b_received", 64'(rcv), 64'd4);
    chk("b2b_sent", 64'(sent), 64'd4);
    chk("b2b_spacing", {63'd0, spacing_bad}, 64'd0);
    chk("b2b_in_ready_toggle", {63'd0, tog_bad}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", {63'd0, busy}, 64'd0);

    // Flush while idle blocks acceptance.
    flush = 1'b1; in_valid = 1'b1; in_kind = 2'b00; in_pc = 64'h5000;
    #1;
    chk("flush_idle_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_no_accept", {63'd0, busy}, 64'd0);

    // Flush in the 2nd cycle of a divide.
    in_valid = 1'b1; in_kind = 2'b10; in_pc = 64'h3000; ex_done = 1'b1;
    ex_jump = 1'b1; ex_target = 64'h3100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    chk("flush_div_enable_before", {63'd0, ex_enable}, 64'd1);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_div_busy", {63'd0, busy}, 64'd0);
    chk("flush_div_enable", {63'd0, ex_enable}, 64'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid || redirect_valid) seen++;
    end
    chk("flush_div_no_output", 64'(seen), 64'd0);
    ex_jump = 1'b0;
    run_op(vecs[0], "post_flush");

    // Flush coincident with completion discards the result.
    @(negedge clk);
    in_valid = 1'b1; in_kind = 2'b00; in_pc = 64'h3200; ex_done = 1'b1; ex_jump = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_busy", {63'd0, busy}, 64'd0);
    chk("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_done_redirect", {63'd0, redirect_valid}, 64'd0);
    ex_jump = 1'b0;

    // Reset in the middle of a multiply with ex_done high.
    in_valid = 1'b1; in_kind = 2'b01; in_pc = 64'h4000; in_rs1 = 64'h33; in_rs2 = 64'h44;
    in_ctrl = c_br; ex_done = 1'b1; ex_result = 64'h99;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mul_busy", {63'd0, busy}, 64'd0);
    chk("rst_mul_enable", {63'd0, ex_enable}, 64'd0);
    chk("rst_mul_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mul_redirect", {63'd0, redirect_valid}, 64'd0);
    chk("rst_mul_ex_pc", ex_pc, 64'd0);
    chk("rst_mul_ex_rs1", ex_rs1, 64'd0);
    chk("rst_mul_ex_ctrl", 64'(ex_ctrl), 64'd0);
    chk("rst_mul_out_pc", out_pc, 64'd0);
    run_op(vecs[1], "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
